// File: rtl/rx_deframer_pkg.sv
// rx_deframer_pkg: state encoding, default sync word and LEN field layout shared by the deframer slice
package rx_deframer_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HUNT    = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [31:0] SYNC_DEFAULT = 32'hA5C3_3C5A;
    localparam int LEN_N_LSB = 0;
    localparam int LEN_N_MSB = 15;
    localparam int LEN_C_LSB = 16;
    localparam int LEN_C_MSB = 31;
endpackage

// File: rtl/rx_deframer_sat_counter.sv
// sat_counter: saturating up-counter where a clear beats a coincident increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_aclk,
    input  logic         i_aresetn,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn)
            o_count <= '0;
        else if (i_clr)
            o_count <= '0;
        else if (i_inc && !(&o_count))
            o_count <= o_count + 1'b1;
    end
endmodule

// File: rtl/rx_deframer.sv
// rx_deframer: hunts sync, validates LEN, forwards payload as AXI-Stream with sof/eof, checks XOR trailer
module rx_deframer
    import rx_deframer_pkg::*;
#(
    parameter logic [31:0] C_SYNC_WORD = SYNC_DEFAULT,
    parameter int unsigned C_MAX_LEN   = 256,
    parameter int          C_CNT_WIDTH = 16
) (
    input  logic                   i_aclk,
    input  logic                   i_aresetn,
    input  logic                   i_enable,
    input  logic                   i_clear_counts,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [31:0]            s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_sof,
    output logic                   m_axis_eof,
    output logic                   o_locked,
    output logic                   o_frame_ok,
    output logic                   o_frame_err,
    output logic [C_CNT_WIDTH-1:0] o_frame_count,
    output logic [C_CNT_WIDTH-1:0] o_err_len_count,
    output logic [C_CNT_WIDTH-1:0] o_err_chk_count
);
    logic [2:0]  state;
    logic [15:0] remaining;
    logic [31:0] acc;
    logic        first;
    logic        s_fire;
    logic [15:0] hdr_n;
    logic [15:0] hdr_c;
    logic        hdr_ok;
    logic        len_err;
    logic        chk_ok;
    logic        chk_err;

    assign s_axis_tready = (state == ST_PAYLOAD) ? (!m_axis_tvalid || m_axis_tready) : (state != ST_IDLE);
    assign s_fire  = s_axis_tvalid && s_axis_tready && i_enable;
    assign hdr_n   = s_axis_tdata[LEN_N_MSB:LEN_N_LSB];
    assign hdr_c   = s_axis_tdata[LEN_C_MSB:LEN_C_LSB];
    assign hdr_ok  = (hdr_c == ~hdr_n) && (hdr_n != '0) && ({16'd0, hdr_n} <= C_MAX_LEN);
    assign len_err = s_fire && (state == ST_LEN) && !hdr_ok;
    assign chk_ok  = s_fire && (state == ST_CHK) && (s_axis_tdata == acc);
    assign chk_err = s_fire && (state == ST_CHK) && (s_axis_tdata != acc);

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            acc           <= '0;
            first         <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_sof    <= 1'b0;
            m_axis_eof    <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_ok  <= chk_ok;
            o_frame_err <= len_err || chk_err;
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (!i_enable) begin
                state    <= ST_IDLE;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_HUNT;
                    ST_HUNT: if (s_fire && s_axis_tdata == C_SYNC_WORD) state <= ST_LEN;
                    ST_LEN: if (s_fire) begin
                        if (hdr_ok) begin
                            remaining <= hdr_n;
                            acc       <= '0;
                            first     <= 1'b1;
                            state     <= ST_PAYLOAD;
                        end else begin
                            o_locked <= 1'b0;
                            state    <= ST_HUNT;
                        end
                    end
                    ST_PAYLOAD: if (s_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_sof    <= first;
                        m_axis_eof    <= remaining == 16'd1;
                        acc           <= acc ^ s_axis_tdata;
                        first         <= 1'b0;
                        remaining     <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= ST_CHK;
                    end
                    ST_CHK: if (s_fire) begin
                        o_locked <= chk_ok;
                        state    <= ST_HUNT;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sat_counter #(.W(C_CNT_WIDTH)) u_frame_cnt (
        .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_inc(chk_ok), .i_clr(i_clear_counts), .o_count(o_frame_count)
    );
    sat_counter #(.W(C_CNT_WIDTH)) u_len_cnt (
        .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_inc(len_err), .i_clr(i_clear_counts), .o_count(o_err_len_count)
    );
    sat_counter #(.W(C_CNT_WIDTH)) u_chk_cnt (
        .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_inc(chk_err), .i_clr(i_clear_counts), .o_count(o_err_chk_count)
    );
endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: scoreboard bench; a 2-bit-counter twin instance exercises counter saturation
module tb_rx_deframer;
    localparam logic [31:0] SYNC = 32'hA5C3_3C5A;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        en = 0;
    logic        clr = 0;
    logic        s_tvalid = 0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1;
    logic [31:0] m_tdata;
    logic        m_sof;
    logic        m_eof;
    logic        locked;
    logic        f_ok;
    logic        f_err;
    logic [15:0] frame_cnt;
    logic [15:0] len_cnt;
    logic [15:0] chk_cnt;
    logic        s2_tready, s2_tvalid, s2_sof, s2_eof, s2_locked, s2_ok, s2_err;
    logic [31:0] s2_tdata;
    logic [1:0]  s2_frame_cnt, s2_len_cnt, s2_chk_cnt;

    int tests = 0;
    int fails = 0;
    int ok_seen = 0;
    int err_seen = 0;
    logic [33:0] exp_q[$];
    logic [31:0] pay [8];
    logic rdy_mode = 0;
    logic rdy_chk = 0;
    logic [3:0] rdy_pat = 4'b1001;

    always #5 clk = ~clk;

    rx_deframer dut (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable(en), .i_clear_counts(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_sof(m_sof), .m_axis_eof(m_eof), .o_locked(locked),
        .o_frame_ok(f_ok), .o_frame_err(f_err), .o_frame_count(frame_cnt),
        .o_err_len_count(len_cnt), .o_err_chk_count(chk_cnt)
    );

    rx_deframer #(.C_CNT_WIDTH(2)) dut_s (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable(en), .i_clear_counts(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s2_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(s2_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(s2_tdata),
        .m_axis_sof(s2_sof), .m_axis_eof(s2_eof), .o_locked(s2_locked),
        .o_frame_ok(s2_ok), .o_frame_err(s2_err), .o_frame_count(s2_frame_cnt),
        .o_err_len_count(s2_len_cnt), .o_err_chk_count(s2_chk_cnt)
    );

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                m_tready = rdy_pat[ph];
                ph = (ph + 1) % 4;
            end else
                m_tready = 1;
        end
    end

    initial begin
        logic        prev_stall = 0;
        logic [33:0] prev_out = '0;
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    tests++;
                    if (m_tvalid !== 1'b1 || {m_tdata, m_sof, m_eof} !== prev_out) begin
                        fails++;
                        $display("FAIL stall_hold: got valid=%b %h sof=%b eof=%b, need valid=1 %h sof=%b eof=%b",
                                 m_tvalid, m_tdata, m_sof, m_eof, prev_out[33:2], prev_out[1], prev_out[0]);
                    end
                end
                if (m_tvalid && m_tready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got %h sof=%b eof=%b, need no word", m_tdata, m_sof, m_eof);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_tdata, m_sof, m_eof} !== e) begin
                            fails++;
                            $display("FAIL out_word: got %h sof=%b eof=%b, need %h sof=%b eof=%b",
                                     m_tdata, m_sof, m_eof, e[33:2], e[1], e[0]);
                        end
                    end
                end
                if (rdy_chk) begin
                    tests++;
                    if (s_tready !== (!m_tvalid || m_tready)) begin
                        fails++;
                        $display("FAIL payload_ready: got %b, need %b", s_tready, !m_tvalid || m_tready);
                    end
                end
                if (f_ok === 1'b1) ok_seen++;
                if (f_err === 1'b1) err_seen++;
                prev_stall = m_tvalid && !m_tready;
                prev_out = {m_tdata, m_sof, m_eof};
            end else
                prev_stall = 0;
        end
    end

    task automatic send_word(input logic [31:0] w, input logic c);
        bit done = 0;
        s_tvalid = 1;
        s_tdata = w;
        clr = c;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 0;
        clr = 0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h not accepted within 64 cycles", w);
        end
    endtask

    function automatic logic [31:0] xor_pay(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= pay[i];
        return x;
    endfunction

    task automatic send_frame(input int n, input logic [31:0] chk, input logic c);
        logic [15:0] ln = 16'(n);
        send_word(SYNC, 0);
        send_word({~ln, ln}, 0);
        for (int i = 0; i < n; i++) exp_q.push_back({pay[i], 1'(i == 0), 1'(i == n - 1)});
        rdy_chk = 1;
        for (int i = 0; i < n; i++) send_word(pay[i], 0);
        rdy_chk = 0;
        send_word(chk, c);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || m_tvalid); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d words still expected, need 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({s_tready, m_tvalid, m_tdata, m_sof, m_eof, locked, f_ok, f_err} !== '0 ||
            {frame_cnt, len_cnt, chk_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got tready=%b valid=%b data=%h locked=%b cnts=%h/%h/%h, need all 0",
                     s_tready, m_tvalid, m_tdata, locked, frame_cnt, len_cnt, chk_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (s_tready !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready: got %b, need 0", s_tready);
        end
        en = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL hunt_ready: got %b, need 1", s_tready);
        end
    endtask

    task automatic test_basic();
        int ok0 = ok_seen;
        pay[0] = 32'd1; pay[1] = 32'd2; pay[2] = 32'd3;
        send_word(SYNC, 0);
        send_word(32'hFFFC_0003, 0);
        rdy_chk = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({pay[i], 1'(i == 0), 1'(i == 2)});
            send_word(pay[i], 0);
            tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== pay[i] || m_sof !== 1'(i == 0) || m_eof !== 1'(i == 2)) begin
                fails++;
                $display("FAIL latency1 word%0d: got valid=%b %h sof=%b eof=%b, need valid=1 %h",
                         i, m_tvalid, m_tdata, m_sof, m_eof, pay[i]);
            end
        end
        rdy_chk = 0;
        send_word(32'h0, 0);
        wait_drain();
        tests++;
        if (ok_seen != ok0 + 1 || frame_cnt !== 16'd1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL basic_status: got ok_pulses=%0d count=%0d locked=%b, need 1 1 1",
                     ok_seen - ok0, frame_cnt, locked);
        end
    endtask

    task automatic test_bad_len();
        int err0 = err_seen;
        send_word(32'h1234_5678, 0);
        send_word(SYNC, 0);
        send_word(32'h0000_0003, 0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (len_cnt !== 16'd1 || err_seen != err0 + 1 || s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL bad_len: got len_cnt=%0d err_pulses=%0d tready=%b valid=%b, need 1 1 1 0",
                     len_cnt, err_seen - err0, s_tready, m_tvalid);
        end
        pay[0] = 32'h10; pay[1] = 32'h20; pay[2] = 32'h40;
        send_frame(3, xor_pay(3), 0);
        wait_drain();
        tests++;
        if (frame_cnt !== 16'd2 || locked !== 1'b1) begin
            fails++;
            $display("FAIL after_bad_len: got count=%0d locked=%b, need 2 1", frame_cnt, locked);
        end
    endtask

    task automatic test_chk_err();
        int err0 = err_seen;
        pay[0] = 32'hDEAD_BEEF;
        send_frame(1, 32'h0, 0);
        wait_drain();
        tests++;
        if (chk_cnt !== 16'd1 || locked !== 1'b0 || err_seen != err0 + 1 || frame_cnt !== 16'd2) begin
            fails++;
            $display("FAIL chk_err: got chk_cnt=%0d locked=%b err_pulses=%0d count=%0d, need 1 0 1 2",
                     chk_cnt, locked, err_seen - err0, frame_cnt);
        end
    endtask

    task automatic test_back_pressure();
        pay[0] = 32'hAAAA_0001; pay[1] = 32'h5555_0002; pay[2] = 32'h0F0F_0003; pay[3] = 32'hF0F0_0004;
        rdy_mode = 1;
        send_frame(4, xor_pay(4), 0);
        wait_drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (frame_cnt !== 16'd3 || locked !== 1'b1) begin
            fails++;
            $display("FAIL back_pressure: got count=%0d locked=%b, need 3 1", frame_cnt, locked);
        end
    endtask

    task automatic test_enable_drop();
        pay[0] = 32'h1111_1111; pay[1] = 32'h2222_2222;
        send_word(SYNC, 0);
        send_word(32'hFFFB_0004, 0);
        exp_q.push_back({pay[0], 1'b1, 1'b0});
        exp_q.push_back({pay[1], 1'b0, 1'b0});
        send_word(pay[0], 0);
        send_word(pay[1], 0);
        en = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (s_tready !== 1'b0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop: got tready=%b locked=%b, need 0 0", s_tready, locked);
        end
        wait_drain();
        en = 1;
        repeat (2) @(posedge clk);
        #1;
        pay[0] = 32'hCAFE_0001; pay[1] = 32'hCAFE_0002;
        send_frame(2, xor_pay(2), 0);
        wait_drain();
        tests++;
        if (frame_cnt !== 16'd4 || locked !== 1'b1) begin
            fails++;
            $display("FAIL reenable: got count=%0d locked=%b, need 4 1", frame_cnt, locked);
        end
    endtask

    task automatic test_saturation();
        int ok0;
        clr = 1;
        @(posedge clk);
        #1;
        clr = 0;
        tests++;
        if ({frame_cnt, len_cnt, chk_cnt} !== '0 || {s2_frame_cnt, s2_len_cnt, s2_chk_cnt} !== '0) begin
            fails++;
            $display("FAIL clear: got %0d/%0d/%0d and %0d/%0d/%0d, need all 0",
                     frame_cnt, len_cnt, chk_cnt, s2_frame_cnt, s2_len_cnt, s2_chk_cnt);
        end
        pay[0] = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++) send_frame(1, pay[0], 0);
        wait_drain();
        tests++;
        if (s2_frame_cnt !== 2'd2 || frame_cnt !== 16'd2) begin
            fails++;
            $display("FAIL near_sat: got %0d and %0d, need 2 and 2", s2_frame_cnt, frame_cnt);
        end
        for (int i = 0; i < 3; i++) send_frame(1, pay[0], 0);
        wait_drain();
        tests++;
        if (s2_frame_cnt !== 2'd3 || frame_cnt !== 16'd5) begin
            fails++;
            $display("FAIL saturate: got %0d and %0d, need 3 and 5", s2_frame_cnt, frame_cnt);
        end
        ok0 = ok_seen;
        send_frame(1, pay[0], 1);
        wait_drain();
        tests++;
        if (frame_cnt !== 16'd0 || s2_frame_cnt !== 2'd0 || ok_seen != ok0 + 1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL clear_wins: got %0d/%0d ok_pulses=%0d locked=%b, need 0/0 1 1",
                     frame_cnt, s2_frame_cnt, ok_seen - ok0, locked);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_chk_err();
        test_back_pressure();
        test_enable_drop();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rx_deframer.md
Name: rx_deframer

Overview:
- Sits directly upstream of the RX decrypt stage. Takes the raw 32-bit word stream from the link and hunts for a sync word.
- Validates a protected length header, then forwards only payload words as an AXI-Stream with sof/eof markers. These feed the decrypt stage's s_axis_tvalid/sof/eof/tdata inputs.
- Checks a trailing XOR checksum word and reports frame and error statistics for the register block.

Parameters:
- C_SYNC_WORD, 32'hA5C3_3C5A, frame sync pattern.
- C_MAX_LEN, 256, maximum payload length in 32-bit words (1..65535).
- C_CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- i_aclk  in  1  clock.
- i_aresetn  in  1  asynchronous active-low reset.
- i_enable  in  1  deframer enable (from the RX enable register).
- i_clear_counts  in  1  single-cycle pulse; clears all statistics counters.
- s_axis_tvalid  in  1  raw link word valid.
- s_axis_tready  out  1  raw link word accepted.
- s_axis_tdata  in  32  raw link word.
- m_axis_tvalid  out  1  payload word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  payload word.
- m_axis_sof  out  1  first payload word of a frame.
- m_axis_eof  out  1  last payload word of a frame.
- o_locked  out  1  last frame passed its checksum.
- o_frame_ok  out  1  one-cycle pulse: frame checksum matched.
- o_frame_err  out  1  one-cycle pulse: length or checksum error.
- o_frame_count  out  C_CNT_WIDTH  good frames.
- o_err_len_count  out  C_CNT_WIDTH  rejected headers.
- o_err_chk_count  out  C_CNT_WIDTH  checksum mismatches.

Behaviour:
- Clock and reset: one clock, i_aclk. i_aresetn is asynchronous, active-low.
- Reset values: every output is 0. Internal state is IDLE, checksum accumulator 0, output register empty.
- Frame format on input: SYNC, LEN, N payload words, CHK.
  - LEN[15:0] = N; LEN[31:16] = ~N.
  - CHK = XOR of the N payload words.
- A word transfers on input when s_axis_tvalid && s_axis_tready, and on output when m_axis_tvalid && m_axis_tready.
- State IDLE:
  - s_axis_tready = 0.
  - Go to HUNT when i_enable = 1.
- State HUNT:
  - s_axis_tready = 1.
  - Each accepted word equal to C_SYNC_WORD moves to LEN; any other word is discarded.
- State LEN:
  - s_axis_tready = 1.
  - Header is valid when upper half == ~lower half, N != 0 and N <= C_MAX_LEN.
  - Valid header: latch N into the remaining-word counter, clear the XOR accumulator, go to PAYLOAD.
  - Invalid header: increment o_err_len_count, pulse o_frame_err, clear o_locked, return to HUNT. A SYNC value in LEN is treated as an ordinary bad header.
- State PAYLOAD:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready. This is a single output register with no bubble under continuous flow.
  - Each accepted word loads the output register one cycle later (latency 1) and is XORed into the accumulator.
  - m_axis_sof is set on the first payload word; m_axis_eof on the word that brings the counter to 0.
  - N = 1 gives sof and eof on the same word.
  - After the last word, go to CHK.
- Output register: holds data, sof and eof stable while m_axis_tvalid && !m_axis_tready.
- State CHK:
  - s_axis_tready = 1.
  - Accepted word == accumulator: pulse o_frame_ok, increment o_frame_count, set o_locked.
  - Mismatch: pulse o_frame_err, increment o_err_chk_count, clear o_locked.
  - Either way go to HUNT. Payload is already forwarded; the error is status only.
- i_enable deasserted in any state:
  - Next state is IDLE and s_axis_tready drops the following cycle.
  - A word already in the output register is still delivered. No eof is synthesised for an aborted frame.
  - o_locked is cleared.
- Counters saturate at all-ones.
- i_clear_counts zeroes all counters. When a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- Reset mid-frame: everything returns to reset values immediately, including dropping m_axis_tvalid.

Decomposition:
- Shared package rx_deframer_pkg holds:
  - the state encoding (IDLE, HUNT, LEN, PAYLOAD, CHK);
  - the default sync word;
  - the LEN field bit positions.
- One sub-module, sat_counter: parameterised width, inc and clr inputs, clear-wins rule. It is instantiated three times.
- The output register stays inline.

Test Plan:
- Reset, enable, stream SYNC, LEN=32'hFFFC_0003, 1, 2, 3, CHK=0, m_axis_tready=1 -> outputs 1(sof), 2, 3(eof) at 1-cycle latency; o_frame_ok pulse; o_frame_count=1; o_locked=1.
- Garbage 32'h1234_5678, then SYNC, LEN=32'h0000_0003 (bad complement) -> no output words; o_err_len_count=1; o_frame_err pulse; state back in HUNT; a following good frame is accepted.
- N=1 frame with payload 32'hDEAD_BEEF and CHK=32'h0000_0000 -> single word with sof=eof=1; o_err_chk_count=1; o_locked=0.
- N=4 frame with m_axis_tready toggling 1,0,0,1,... -> no word lost or duplicated; data, sof and eof stable while stalled; s_axis_tready low only while the register is full and not draining.
- i_enable dropped after the 2nd of 4 payload words -> word 2 still delivered; no eof; s_axis_tready=0; re-enable and a good frame is received normally.
- Set counters near saturation (0xFFFE) and generate 3 good frames -> o_frame_count holds 0xFFFF; i_clear_counts on the same cycle as an o_frame_ok increment -> 0.
